roc_multi: RTL and testbench
============================

Name: roc_multi

Overview:
- Parametrised read-limited memory: each entry is written once and may then be read a programmable number of times (1..2^CW) before it self-clears.
- Per-entry valid bits and read budgets replace a single global "already read" flag.
- Separate write and read ports, one-cycle read latency, occupancy tracking and status pulses.
- Sits in front of consumers that must see each data word a bounded number of times, e.g. one-shot token or key stores.

Parameters:
DW, 8, data width in bits
AW, 4, address width
DEP, 16, number of entries; must equal 2**AW
CW, 2, read-budget width; budget range 1..2**CW

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr  input  1  write strobe
waddr  input  AW  write address
wdata  input  DW  write data
wcnt  input  CW  permitted read count; 0 encodes 2**CW
rd  input  1  read strobe
raddr  input  AW  read address
rdata  output  DW  read data, registered
rvalid  output  1  one-cycle pulse: rdata holds a valid entry
rmiss  output  1  one-cycle pulse: read hit an empty entry
wovr  output  1  one-cycle pulse: write overwrote a still-valid entry
count  output  AW+1  number of valid entries
full  output  1  count == DEP, combinational from count
empty  output  1  count == 0, combinational from count

Behaviour:
- Per-entry state:
  - mem[i] (DW bits)
  - vld[i] (1 bit)
  - rem[i] (CW+1 bits, remaining reads, 1..2**CW while valid)
- Reset, asserted on a clock edge:
  - all mem = 0, vld = 0, rem = 0
  - rdata = 0, rvalid = 0, rmiss = 0, wovr = 0, count = 0
  - Reset overrides wr/rd in the same cycle.
  - Reset mid-operation discards all entries and any pending pulse.
- Pulses: rvalid, rmiss and wovr are 0 in any cycle without the corresponding event.
- Write (wr=1):
  - mem[waddr] <= wdata, vld <= 1, rem <= (wcnt==0 ? 2**CW : wcnt).
  - If the entry was already valid, wovr = 1 next cycle.
- Read (rd=1), result visible the cycle after the rd edge:
  - Entry valid: rdata <= mem[raddr], rvalid = 1, rem decrements.
  - If rem was 1: vld <= 0 and mem[raddr] <= 0 (read data is still returned on this final read).
  - Entry invalid: rdata <= 0, rvalid = 0, rmiss = 1.
  - rdata holds its value when rd=0.
- Simultaneous wr and rd, different addresses: fully independent.
- Simultaneous wr and rd, same address:
  - The read sees the pre-write contents and state (read-before-write).
  - The write's state wins: entry ends valid with wdata and the new budget; the decrement/clear from the read is discarded.
  - rmiss/rvalid follow the pre-write state; wovr follows the pre-write vld.
- count:
  - Next value = count + (entries becoming valid) − (entries becoming invalid) this cycle.
  - Net effect of one write plus one read ranges −1..+1.
  - Never wraps; at most DEP.
- Writes to a full memory at an invalid address are impossible by construction (full implies all valid), so the only write-when-full case is an overwrite: wovr = 1, count unchanged.
- No handshake back-pressure; rd and wr are accepted every cycle.

Test Plan:
- Reset then rd all 16 addresses → rmiss = 1 each cycle, rdata = 0, count = 0, empty = 1.
- wr addr 3, data 0xA5, wcnt 2; rd addr 3 three times:
  - 1st read → rvalid = 1, rdata = 0xA5
  - 2nd read → rvalid = 1, rdata = 0xA5, count goes 1 → 0
  - 3rd read → rmiss = 1, rdata = 0
- wcnt = 0 on addr 7, data 0x3C → four successful reads of 0x3C, fifth read misses.
- Fill all 16 addresses → full = 1, count = 16; rewrite addr 0 → wovr = 1, count stays 16.
- Same-cycle wr/rd addr 5:
  - Setup: addr 5 holds 0x11 with rem 1; write 0x22, wcnt 1.
  - Response: rdata = 0x11, rvalid = 1, count unchanged; next read of addr 5 → 0x22.
- Assert rst mid-stream with 4 valid entries and rd active → next cycle rvalid = 0, rdata = 0, count = 0; all subsequent reads miss.

Source files
------------

// File: rtl/roc_multi_if.sv
// roc_multi_if: bus bundle for the read-limited memory.
//   master : drives write/read requests, observes read results and status.
//   slave  : the memory itself.
// Signals:
//   wr, waddr, wdata, wcnt : write strobe, address, data, read budget (0 = 2**CW)
//   rd, raddr              : read strobe and address
//   rdata, rvalid, rmiss   : registered read data, hit pulse, miss pulse
//   wovr                   : pulse when a write replaced a still-valid entry
//   count, full, empty     : occupancy
interface roc_multi_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4,
    parameter int unsigned CW = 2
);
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [CW-1:0] wcnt;
    logic          rd;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rmiss;
    logic          wovr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    modport master (
        output wr, waddr, wdata, wcnt, rd, raddr,
        input  rdata, rvalid, rmiss, wovr, count, full, empty
    );

    modport slave (
        input  wr, waddr, wdata, wcnt, rd, raddr,
        output rdata, rvalid, rmiss, wovr, count, full, empty
    );
endinterface

// File: rtl/roc_multi.sv
// roc_multi: read-limited memory. Each entry is written once with a read
// budget (1..2**CW) and self-clears after its last permitted read.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : roc_multi_if.slave (write port, read port, pulses, occupancy)
// Read latency is one cycle. A same-address write and read in one cycle
// reads the old contents, while the write's new state is what remains.
module roc_multi #(
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 4,
    parameter int unsigned DEP = 16,
    parameter int unsigned CW  = 2
) (
    input logic        clk,
    input logic        rst,
    roc_multi_if.slave bus
);
    logic [DW-1:0]  mem_q [DEP];
    logic [DEP-1:0] vld_q;
    logic [CW:0]    rem_q [DEP];

    logic [DW-1:0]  rdata_q;
    logic           rvalid_q;
    logic           rmiss_q;
    logic           wovr_q;
    logic [AW:0]    count_q;
    logic [AW:0]    count_d;

    logic           rd_hit;
    logic           rd_last;
    logic           rd_clr;
    logic           wr_new;
    logic           wr_ovr;
    logic [CW:0]    wr_budget;

    always_comb begin
        rd_hit    = bus.rd && vld_q[bus.raddr];
        rd_last   = rd_hit && (rem_q[bus.raddr] == (CW+1)'(1));
        // A same-address write re-validates the entry, so the final read
        // does not reduce occupancy.
        rd_clr    = rd_last && !(bus.wr && (bus.waddr == bus.raddr));
        wr_ovr    = bus.wr && vld_q[bus.waddr];
        wr_new    = bus.wr && !vld_q[bus.waddr];
        wr_budget = (bus.wcnt == '0) ? {1'b1, {CW{1'b0}}} : {1'b0, bus.wcnt};
        count_d   = count_q;
        if (wr_new) count_d = count_d + (AW+1)'(1);
        if (rd_clr) count_d = count_d - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEP; i++) begin
                mem_q[i] <= '0;
                rem_q[i] <= '0;
            end
            vld_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rmiss_q  <= 1'b0;
            wovr_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            rvalid_q <= rd_hit;
            rmiss_q  <= bus.rd && !vld_q[bus.raddr];
            wovr_q   <= wr_ovr;
            count_q  <= count_d;
            if (bus.rd) rdata_q <= rd_hit ? mem_q[bus.raddr] : '0;
            if (rd_hit) begin
                rem_q[bus.raddr] <= rem_q[bus.raddr] - (CW+1)'(1);
                if (rd_last) begin
                    vld_q[bus.raddr] <= 1'b0;
                    mem_q[bus.raddr] <= '0;
                end
            end
            // Placed after the read update so a same-address write wins.
            if (bus.wr) begin
                mem_q[bus.waddr] <= bus.wdata;
                vld_q[bus.waddr] <= 1'b1;
                rem_q[bus.waddr] <= wr_budget;
            end
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rmiss  = rmiss_q;
    assign bus.wovr   = wovr_q;
    assign bus.count  = count_q;
    assign bus.full   = (count_q == (AW+1)'(DEP));
    assign bus.empty  = (count_q == '0);
endmodule

// File: tb/tb_roc_multi.sv
// Bench for roc_multi: directed vector table, hand sequences for fill /
// overwrite / mid-stream reset, then random traffic against a model.
module tb_roc_multi;
    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 4;
    localparam int unsigned DEP = 16;
    localparam int unsigned CW  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    roc_multi_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    roc_multi #(.DW(DW), .AW(AW), .DEP(DEP), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          r;
        logic          w;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [CW-1:0] wc;
        logic          rdv;
        logic [AW-1:0] ra;
        logic [DW-1:0] e_rdata;
        logic          e_rvalid;
        logic          e_rmiss;
        logic          e_wovr;
        int            e_count;
    } vec_t;

    vec_t tv[$];

    // Reference model state
    logic [DW-1:0] m_data [DEP];
    bit            m_vld  [DEP];
    int            m_rem  [DEP];
    logic [DW-1:0] m_rdata;

    function automatic vec_t mk(logic r, logic w, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                logic [CW-1:0] wc, logic rdv, logic [AW-1:0] ra,
                                logic [DW-1:0] er, logic ev, logic em, logic ew, int ec);
        vec_t v;
        v.r = r; v.w = w; v.wa = wa; v.wd = wd; v.wc = wc; v.rdv = rdv; v.ra = ra;
        v.e_rdata = er; v.e_rvalid = ev; v.e_rmiss = em; v.e_wovr = ew; v.e_count = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [DW-1:0] er, input logic ev,
                           input logic em, input logic ew, input int ec);
        chk({tag, ".rdata"},  32'(bus.rdata),  32'(er));
        chk({tag, ".rvalid"}, 32'(bus.rvalid), 32'(ev));
        chk({tag, ".rmiss"},  32'(bus.rmiss),  32'(em));
        chk({tag, ".wovr"},   32'(bus.wovr),   32'(ew));
        chk({tag, ".count"},  32'(bus.count),  32'(ec));
        chk({tag, ".full"},   32'(bus.full),   32'(ec == DEP));
        chk({tag, ".empty"},  32'(bus.empty),  32'(ec == 0));
    endtask

    // Apply inputs away from the edge, then sample 1 ns after the edge.
    task automatic drive(input logic r, input logic w, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [CW-1:0] wc,
                         input logic rdv, input logic [AW-1:0] ra);
        rst = r; bus.wr = w; bus.waddr = wa; bus.wdata = wd; bus.wcnt = wc;
        bus.rd = rdv; bus.raddr = ra;
        @(posedge clk);
        #1;
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEP; i++) n += m_vld[i] ? 1 : 0;
        return n;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEP; i++) begin
            m_data[i] = '0; m_vld[i] = 1'b0; m_rem[i] = 0;
        end
        m_rdata = '0;
    endfunction

    initial begin
        logic          r, w, rdv;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, er;
        logic [CW-1:0] wc;
        logic          ev, em, ew;
        int            ec;

        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);

        // ---------------- directed table ----------------
        tv.push_back(mk(1, 0, 0, 8'h00, 0, 1, 3, 8'h00, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 3, 8'h00, 0, 1, 0, 0));
        tv.push_back(mk(0, 1, 3, 8'hA5, 2, 0, 0, 8'h00, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 3, 8'hA5, 1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 3, 8'hA5, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 3, 8'h00, 0, 1, 0, 0));
        tv.push_back(mk(0, 1, 7, 8'h3C, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 7, 8'h3C, 1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 7, 8'h3C, 1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h3C, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 7, 8'h3C, 1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 7, 8'h3C, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 7, 8'h00, 0, 1, 0, 0));
        tv.push_back(mk(0, 1, 5, 8'h11, 1, 0, 0, 8'h00, 0, 0, 0, 1));
        tv.push_back(mk(0, 1, 5, 8'h22, 1, 1, 5, 8'h11, 1, 0, 1, 1));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 5, 8'h22, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 5, 8'h00, 0, 1, 0, 0));
        tv.push_back(mk(0, 1, 2, 8'h44, 1, 0, 0, 8'h00, 0, 0, 0, 1));
        tv.push_back(mk(0, 1, 9, 8'h55, 1, 1, 2, 8'h44, 1, 0, 0, 1));
        tv.push_back(mk(0, 1, 9, 8'h66, 3, 1, 9, 8'h55, 1, 0, 1, 1));
        tv.push_back(mk(0, 0, 0, 8'h00, 0, 1, 9, 8'h66, 1, 0, 0, 1));

        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].w, tv[i].wa, tv[i].wd, tv[i].wc, tv[i].rdv, tv[i].ra);
            chk_out($sformatf("vec%0d", i), tv[i].e_rdata, tv[i].e_rvalid, tv[i].e_rmiss,
                    tv[i].e_wovr, tv[i].e_count);
        end

        // ---------------- empty sweep after reset ----------------
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        for (int a = 0; a < DEP; a++) begin
            drive(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(a));
            chk_out($sformatf("sweep%0d", a), 8'h00, 1'b0, 1'b1, 1'b0, 0);
        end

        // ---------------- fill and overwrite when full ----------------
        for (int a = 0; a < DEP; a++) begin
            drive(1'b0, 1'b1, AW'(a), DW'(a + 8'h10), 2'd1, 1'b0, '0);
            chk_out($sformatf("fill%0d", a), 8'h00, 1'b0, 1'b0, 1'b0, a + 1);
        end
        drive(1'b0, 1'b1, '0, 8'hEE, 2'd1, 1'b0, '0);
        chk_out("ovr_full", 8'h00, 1'b0, 1'b0, 1'b1, DEP);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, '0);
        chk_out("ovr_read", 8'hEE, 1'b1, 1'b0, 1'b0, DEP - 1);

        // ---------------- reset mid-stream ----------------
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        for (int a = 0; a < 4; a++) drive(1'b0, 1'b1, AW'(a), DW'(8'hC0 + a), 2'd3, 1'b0, '0);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd1);
        chk_out("pre_rst", 8'hC1, 1'b1, 1'b0, 1'b0, 4);
        drive(1'b1, 1'b1, 4'd6, 8'h77, 2'd1, 1'b1, 4'd2);
        chk_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 0);
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(a));
            chk_out($sformatf("post_rst%0d", a), 8'h00, 1'b0, 1'b1, 1'b0, 0);
        end

        // ---------------- random traffic vs model ----------------
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(0, 199) == 0);
            w   = ($urandom_range(0, 99) < 45);
            rdv = ($urandom_range(0, 99) < 60);
            wa  = AW'($urandom_range(0, DEP - 1));
            ra  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEP - 1));
            wd  = DW'($urandom);
            wc  = CW'($urandom);
            if (r) begin
                model_reset();
                er = '0; ev = 1'b0; em = 1'b0; ew = 1'b0;
            end else begin
                ev = rdv && m_vld[ra];
                em = rdv && !m_vld[ra];
                er = rdv ? (m_vld[ra] ? m_data[ra] : '0) : m_rdata;
                ew = w && m_vld[wa];
                if (ev) begin
                    m_rem[ra]--;
                    if (m_rem[ra] == 0) begin
                        m_vld[ra]  = 1'b0;
                        m_data[ra] = '0;
                    end
                end
                if (w) begin
                    m_data[wa] = wd;
                    m_vld[wa]  = 1'b1;
                    m_rem[wa]  = (wc == 0) ? (1 << CW) : int'(wc);
                end
                m_rdata = er;
            end
            ec = model_count();
            drive(r, w, wa, wd, wc, rdv, ra);
            chk_out($sformatf("rnd%0d", c), er, ev, em, ew, ec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
